// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - requester handshakes and memory-side signals of the data memory arbiter
interface dmem_arbiter_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic                  a_req_i;
  logic                  a_we_i;
  logic [ADDR_WIDTH-1:0] a_addr_i;
  logic [DATA_WIDTH-1:0] a_wdata_i;
  logic                  a_lock_i;
  logic                  a_gnt_o;
  logic                  a_rvalid_o;
  logic [DATA_WIDTH-1:0] a_rdata_o;

  logic                  b_req_i;
  logic                  b_we_i;
  logic [ADDR_WIDTH-1:0] b_addr_i;
  logic [DATA_WIDTH-1:0] b_wdata_i;
  logic                  b_lock_i;
  logic                  b_gnt_o;
  logic                  b_rvalid_o;
  logic [DATA_WIDTH-1:0] b_rdata_o;

  logic [ADDR_WIDTH-1:0] mem_address_o;
  logic [DATA_WIDTH-1:0] mem_write_data_o;
  logic                  mem_MemWrite_o;
  logic                  mem_MemRead_o;
  logic [DATA_WIDTH-1:0] mem_data_read_i;

  modport slave (
    input  a_req_i, a_we_i, a_addr_i, a_wdata_i, a_lock_i,
    output a_gnt_o, a_rvalid_o, a_rdata_o,
    input  b_req_i, b_we_i, b_addr_i, b_wdata_i, b_lock_i,
    output b_gnt_o, b_rvalid_o, b_rdata_o,
    output mem_address_o, mem_write_data_o, mem_MemWrite_o, mem_MemRead_o,
    input  mem_data_read_i
  );

  modport master (
    output a_req_i, a_we_i, a_addr_i, a_wdata_i, a_lock_i,
    input  a_gnt_o, a_rvalid_o, a_rdata_o,
    output b_req_i, b_we_i, b_addr_i, b_wdata_i, b_lock_i,
    input  b_gnt_o, b_rvalid_o, b_rdata_o,
    input  mem_address_o, mem_write_data_o, mem_MemWrite_o, mem_MemRead_o,
    output mem_data_read_i
  );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port round-robin arbiter for the single-port data memory
// Define DMEM_ARB_LOCK_EN to build the bus lock with idle-timeout release.
module dmem_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int LOCK_MAX   = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  dmem_arbiter_if.slave bus
);
  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  logic rr_last_q, rr_last_d;
  logic rd_own_a_q, rd_own_a_d;
  logic rd_own_b_q, rd_own_b_d;
  logic gnt_a, gnt_b;
  logic arb_a;

  // A wins free arbitration when alone or when B was the last winner
  assign arb_a = bus.a_req_i && (!bus.b_req_i || (rr_last_q == PORT_B));

`ifdef DMEM_ARB_LOCK_EN
  typedef enum logic [1:0] {IDLE, LOCK_A, LOCK_B} state_t;
  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  state_t           state_q;
  logic [CNT_W-1:0] idle_cnt_q;
  logic             own_gnt, own_lock;

  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    case (state_q)
      LOCK_A:  gnt_a = bus.a_req_i;
      LOCK_B:  gnt_b = bus.b_req_i;
      default: begin
        gnt_a = arb_a;
        gnt_b = bus.b_req_i && !arb_a;
      end
    endcase
  end

  assign own_gnt  = (state_q == LOCK_A) ? gnt_a : gnt_b;
  assign own_lock = (state_q == LOCK_A) ? bus.a_lock_i : bus.b_lock_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idle_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          idle_cnt_q <= '0;
          if (gnt_a && bus.a_lock_i)      state_q <= LOCK_A;
          else if (gnt_b && bus.b_lock_i) state_q <= LOCK_B;
        end
        LOCK_A, LOCK_B: begin
          // the owner is always granted when it asks, so no grant means an idle owner cycle
          if (own_gnt) begin
            idle_cnt_q <= '0;
            if (!own_lock) state_q <= IDLE;
          end else if (idle_cnt_q == CNT_W'(LOCK_MAX - 1)) begin
            idle_cnt_q <= '0;
            state_q    <= IDLE;
          end else begin
            idle_cnt_q <= idle_cnt_q + CNT_W'(1);
          end
        end
        default: begin
          idle_cnt_q <= '0;
          state_q    <= IDLE;
        end
      endcase
    end
  end
`else
  localparam int unused_lock_max = LOCK_MAX;
  logic unused_lock;
  assign unused_lock = bus.a_lock_i ^ bus.b_lock_i;
  assign gnt_a = arb_a;
  assign gnt_b = bus.b_req_i && !arb_a;
`endif

  assign bus.a_gnt_o = gnt_a;
  assign bus.b_gnt_o = gnt_b;

  always_comb begin
    bus.mem_address_o    = '0;
    bus.mem_write_data_o = '0;
    bus.mem_MemWrite_o   = 1'b0;
    bus.mem_MemRead_o    = 1'b0;
    if (gnt_a) begin
      bus.mem_address_o    = bus.a_addr_i;
      bus.mem_write_data_o = bus.a_wdata_i;
      bus.mem_MemWrite_o   = bus.a_we_i;
      bus.mem_MemRead_o    = !bus.a_we_i;
    end else if (gnt_b) begin
      bus.mem_address_o    = bus.b_addr_i;
      bus.mem_write_data_o = bus.b_wdata_i;
      bus.mem_MemWrite_o   = bus.b_we_i;
      bus.mem_MemRead_o    = !bus.b_we_i;
    end
  end

  always_comb begin
    rr_last_d  = rr_last_q;
    if (gnt_a)      rr_last_d = PORT_A;
    else if (gnt_b) rr_last_d = PORT_B;
    rd_own_a_d = gnt_a && !bus.a_we_i;
    rd_own_b_d = gnt_b && !bus.b_we_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last_q  <= PORT_B;
      rd_own_a_q <= 1'b0;
      rd_own_b_q <= 1'b0;
    end else begin
      rr_last_q  <= rr_last_d;
      rd_own_a_q <= rd_own_a_d;
      rd_own_b_q <= rd_own_b_d;
    end
  end

  // memory read data is already registered, so it lines up with the owner flag
  assign bus.a_rvalid_o = rd_own_a_q;
  assign bus.b_rvalid_o = rd_own_b_q;
  assign bus.a_rdata_o  = rd_own_a_q ? bus.mem_data_read_i : '0;
  assign bus.b_rdata_o  = rd_own_b_q ? bus.mem_data_read_i : '0;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed and randomized checks of dmem_arbiter against a transaction-level model
module tb_dmem_arbiter;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int LM = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  dmem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LOCK_MAX(LM)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  function automatic logic [31:0] init_word(input int i);
    logic [7:0] b;
    b = 8'(i);
    return {b, ~b, 8'h5A, b ^ 8'h3C};
  endfunction

  // synchronous memory with registered read data
  logic [31:0] mem [256];
  logic mem_init = 1'b0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
      mem_init <= 1'b1;
    end else begin
      if (bus.mem_MemWrite_o) mem[bus.mem_address_o] <= bus.mem_write_data_o;
      if (bus.mem_MemRead_o)  bus.mem_data_read_i <= mem[bus.mem_address_o];
    end
  end

  // reference model state: last winner (0=A,1=B), pending read, shadow memory, lock owner (0 none,1 A,2 B)
  int          last_win = 1;
  bit          pend_v = 0;
  int          pend_p = 0;
  logic [31:0] pend_d = '0;
  logic [31:0] shadow [256];
  int          owner = 0;
  int          idle = 0;
  logic        obs_a_gnt, obs_b_gnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_a(input logic req, input logic we, input logic [7:0] addr,
                         input logic [31:0] wd, input logic lk);
    bus.a_req_i = req; bus.a_we_i = we; bus.a_addr_i = addr; bus.a_wdata_i = wd; bus.a_lock_i = lk;
  endtask

  task automatic drive_b(input logic req, input logic we, input logic [7:0] addr,
                         input logic [31:0] wd, input logic lk);
    bus.b_req_i = req; bus.b_we_i = we; bus.b_addr_i = addr; bus.b_wdata_i = wd; bus.b_lock_i = lk;
  endtask

  // one clock: check combinational and response outputs at negedge, then advance the model at posedge
  task automatic step();
    bit ea, eb, ewe, ere;
    logic [7:0] eaddr;
    logic [31:0] ewd;
    @(negedge clk);
    ea = 0; eb = 0;
    if (owner == 1)      ea = bus.a_req_i;
    else if (owner == 2) eb = bus.b_req_i;
    else if (bus.a_req_i && bus.b_req_i) begin
      if (last_win == 1) ea = 1; else eb = 1;
    end else begin
      ea = bus.a_req_i; eb = bus.b_req_i;
    end
    eaddr = '0; ewd = '0; ewe = 0; ere = 0;
    if (ea) begin eaddr = bus.a_addr_i; ewd = bus.a_wdata_i; ewe = bus.a_we_i; ere = !bus.a_we_i; end
    if (eb) begin eaddr = bus.b_addr_i; ewd = bus.b_wdata_i; ewe = bus.b_we_i; ere = !bus.b_we_i; end
    obs_a_gnt = bus.a_gnt_o;
    obs_b_gnt = bus.b_gnt_o;
    chk("a_gnt", bus.a_gnt_o, ea);
    chk("b_gnt", bus.b_gnt_o, eb);
    chk("mem_addr", bus.mem_address_o, eaddr);
    chk("mem_wdata", bus.mem_write_data_o, ewd);
    chk("mem_we", bus.mem_MemWrite_o, ewe);
    chk("mem_re", bus.mem_MemRead_o, ere);
    chk("a_rvalid", bus.a_rvalid_o, pend_v && pend_p == 0);
    chk("a_rdata", bus.a_rdata_o, (pend_v && pend_p == 0) ? pend_d : 32'h0);
    chk("b_rvalid", bus.b_rvalid_o, pend_v && pend_p == 1);
    chk("b_rdata", bus.b_rdata_o, (pend_v && pend_p == 1) ? pend_d : 32'h0);
    @(posedge clk);
    pend_v = 0;
    if (ea || eb) begin
      last_win = ea ? 0 : 1;
      if (ere) begin pend_v = 1; pend_p = last_win; pend_d = shadow[eaddr]; end
      else shadow[eaddr] = ewd;
    end
`ifdef DMEM_ARB_LOCK_EN
    if (owner == 0) begin
      if (ea && bus.a_lock_i)      owner = 1;
      else if (eb && bus.b_lock_i) owner = 2;
      idle = 0;
    end else if ((owner == 1 && ea) || (owner == 2 && eb)) begin
      idle = 0;
      if (!((owner == 1) ? bus.a_lock_i : bus.b_lock_i)) owner = 0;
    end else begin
      idle++;
      if (idle == LM) begin owner = 0; idle = 0; end
    end
`endif
    #1;
  endtask

  initial begin
    logic [3:0] seq;
    int n;
    for (int i = 0; i < 256; i++) shadow[i] = init_word(i);
    drive_a(0, 0, 0, 0, 0);
    drive_b(0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // reset state
    chk("rst_a_rvalid", bus.a_rvalid_o, 0);
    chk("rst_b_rvalid", bus.b_rvalid_o, 0);
    step();

    // A read 0x05 alone
    drive_a(1, 0, 8'h05, 32'h0, 0);
    step();
    drive_a(0, 0, 0, 0, 0);
    chk("a_rd05_rvalid", bus.a_rvalid_o, 1);
    chk("a_rd05_rdata", bus.a_rdata_o, init_word(5));
    chk("a_rd05_b_rvalid", bus.b_rvalid_o, 0);
    step();

    // B write 0x33 then read back on the next cycle
    drive_b(1, 1, 8'h33, 32'h12345678, 0);
    step();
    drive_b(1, 0, 8'h33, 32'h0, 0);
    step();
    drive_b(0, 0, 0, 0, 0);
    chk("b_raw_rvalid", bus.b_rvalid_o, 1);
    chk("b_raw_rdata", bus.b_rdata_o, 32'h12345678);
    step();

    // sustained conflict alternates A, B, A, B
    drive_a(1, 0, 8'h10, 32'h0, 0);
    drive_b(1, 1, 8'h20, 32'hDEADBEEF, 0);
    for (int k = 0; k < 4; k++) begin
      step();
      seq[3-k] = obs_a_gnt;
    end
    chk("rr_order", seq, 4'b1010);
    drive_a(0, 0, 0, 0, 0);
    drive_b(0, 0, 0, 0, 0);
    step();
    chk("mem_20", mem[8'h20], 32'hDEADBEEF);

    // reset in the cycle after an A read grant
    drive_a(1, 0, 8'h07, 32'h0, 0);
    step();
    drive_a(0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_a_rvalid", bus.a_rvalid_o, 0);
    chk("rst_mid_a_rdata", bus.a_rdata_o, 0);
    pend_v = 0; last_win = 1; owner = 0; idle = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_hold_a_rvalid", bus.a_rvalid_o, 0);
    step();
    drive_a(1, 0, 8'h08, 32'h0, 0);
    drive_b(1, 0, 8'h09, 32'h0, 0);
    step();
    chk("rst_first_conflict_a", obs_a_gnt, 1);
    drive_a(0, 0, 0, 0, 0);
    drive_b(0, 0, 0, 0, 0);
    step();

`ifdef DMEM_ARB_LOCK_EN
    // lock held across B requests until an unlocked A transfer
    drive_a(1, 0, 8'h40, 32'h0, 1);
    step();
    drive_a(0, 0, 0, 0, 0);
    drive_b(1, 0, 8'h50, 32'h0, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("lock_b_blocked", obs_b_gnt, 0);
    end
    drive_a(1, 1, 8'h40, 32'hCAFEF00D, 0);
    step();
    chk("lock_release_a", obs_a_gnt, 1);
    drive_a(0, 0, 0, 0, 0);
    step();
    chk("lock_release_b", obs_b_gnt, 1);
    drive_b(0, 0, 0, 0, 0);
    step();

    // idle-timeout release
    drive_a(1, 0, 8'h41, 32'h0, 1);
    step();
    drive_a(0, 0, 0, 0, 0);
    drive_b(1, 0, 8'h51, 32'h0, 0);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (obs_b_gnt) break;
      n++;
    end
    chk("lock_timeout_cycles", n, LM);
    drive_b(0, 0, 0, 0, 0);
    step();
`endif

    // randomized traffic over a small address window to exercise read-after-write
    for (int k = 0; k < 400; k++) begin
      drive_a(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)),
              $urandom, 1'($urandom_range(0, 7) == 0));
      drive_b(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)),
              $urandom, 1'($urandom_range(0, 7) == 0));
      step();
    end
    drive_a(0, 0, 0, 0, 0);
    drive_b(0, 0, 0, 0, 0);
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter that shares the single-port data memory between port A (core load/store path) and port B (DMA/debug loader).
- Drives the memory's address, write-data, MemWrite and MemRead inputs, and routes the registered read data back to the requester that issued the read.
- Round-robin on conflict; optional bus lock for atomic read-modify-write sequences.

Parameters:
ADDR_WIDTH, 8, word address width; must match the data memory.
DATA_WIDTH, 32, data word width.
LOCK_MAX, 16, idle cycles a lock owner may hold the memory before forced release (lock feature only); LOCK_MAX >= 1.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous, active-low reset
a_req_i  input  1  port A request
a_we_i  input  1  port A write (1) / read (0)
a_addr_i  input  ADDR_WIDTH  port A address
a_wdata_i  input  DATA_WIDTH  port A write data
a_lock_i  input  1  port A lock request, sampled with a granted transfer
a_gnt_o  output  1  port A grant; transfer occurs at the clk edge where req && gnt
a_rvalid_o  output  1  port A read data valid
a_rdata_o  output  DATA_WIDTH  port A read data
b_req_i, b_we_i, b_addr_i, b_wdata_i, b_lock_i, b_gnt_o, b_rvalid_o, b_rdata_o: same as port A, for port B
mem_address_o  output  ADDR_WIDTH  to memory address input
mem_write_data_o  output  DATA_WIDTH  to memory write data input
mem_MemWrite_o  output  1  to memory write enable
mem_MemRead_o  output  1  to memory read enable
mem_data_read_i  input  DATA_WIDTH  from memory registered read data

Behaviour:
- Clock is clk. Reset is rst_n, asynchronous and active-low.
- Reset values:
  - rr_last = B, so A wins the first conflict.
  - state = IDLE; lock counter = 0; read owner = none.
  - a_rvalid_o = b_rvalid_o = 0.
- Grants are combinational from req, rr_last and state. At most one grant per cycle.
  - IDLE, one requester: that port is granted.
  - IDLE, both requesting: the port not equal to rr_last is granted.
  - rr_last updates to the granted port at each granted edge.
  - Back-to-back grants to the same port are allowed when the other port is idle.
- Memory side:
  - Granted cycle: mem_address_o = granted addr. mem_write_data_o = granted wdata.
  - Granted write: mem_MemWrite_o = 1, mem_MemRead_o = 0.
  - Granted read: mem_MemRead_o = 1, mem_MemWrite_o = 0.
  - No grant: all mem outputs = 0.
- Read latency is 1 cycle.
  - On a granted read edge, register the owner (A/B).
  - In the next cycle, the owner's rvalid_o = 1 and its rdata_o = mem_data_read_i.
  - The non-owner's rvalid_o = 0.
  - rdata_o of the non-owner = 0 while its rvalid_o = 0.
- Writes have no response. The write completes at the granted edge.
- A new grant is allowed in the same cycle as a pending rvalid (fully pipelined, one transfer per cycle).
- Write then read of the same address on consecutive cycles returns the new data.
- Reset mid-operation: a pending rvalid is dropped, no rvalid is asserted after reset, and arbitration restarts from the reset values.

Optional Feature:
- Macro: DMEM_ARB_LOCK_EN.
- Defined:
  - FSM states IDLE, LOCK_A, LOCK_B.
  - A granted transfer with lock_i = 1 moves the FSM to LOCK_<port>.
  - In LOCK_X, only port X can be granted; the other port's gnt = 0 regardless of req.
  - A granted X transfer with lock_i = 0 returns to IDLE after that transfer.
  - Idle counter: clears on each X grant and increments on cycles with no X request.
  - When the counter reaches LOCK_MAX, force IDLE at that edge and clear the counter.
  - Lock with LOCK_MAX idle then immediate re-request is handled as a fresh IDLE arbitration.
- Undefined:
  - a_lock_i and b_lock_i remain as ports but are ignored.
  - The FSM stays in IDLE; no counter is built.

Test Plan:
- Reset, then A read addr 0x05 alone -> a_gnt_o = 1, mem_MemRead_o = 1, mem_address_o = 0x05; next cycle a_rvalid_o = 1, a_rdata_o = mem value, b_rvalid_o = 0.
- Both request every cycle for 4 cycles (A read 0x10, B write 0x20 data 0xDEADBEEF) -> grant order A, B, A, B; memory word 0x20 = 0xDEADBEEF.
- B write 0x33 = 0x12345678, then B read 0x33 on the next cycle -> b_rvalid_o one cycle after the read grant with b_rdata_o = 0x12345678.
- rst_n asserted low in the cycle after an A read grant -> a_rvalid_o = 0 immediately and stays 0 after release; the next conflict grants A.
- With DMEM_ARB_LOCK_EN: A read 0x40 with a_lock_i = 1 while B requests continuously -> b_gnt_o = 0 until A writes 0x40 with a_lock_i = 0; B is granted the following cycle.
- With DMEM_ARB_LOCK_EN and LOCK_MAX = 16: A locks, then drops req -> b_gnt_o rises exactly 16 cycles after A's last grant.
